// File: rtl/canny_pkg.sv
// rtl/canny_pkg.sv - shared constants and types for the Canny pixel chain
// Purpose: pixel width, Gaussian kernel weights, adder-tree width and the
//          FSM state encoding used by gaussian_blur_3x3.
// Ports:   none (package).
package canny_pkg;

  localparam int DW    = 8;       // gray pixel width
  localparam int SUM_W = DW + 4;  // kernel weights total 16 -> 4 extra bits

  // Kernel [1 2 1; 2 4 2; 1 2 1]
  localparam int K_CORNER = 1;
  localparam int K_EDGE   = 2;
  localparam int K_CENTRE = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } blur_state_t;

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-clock DEPTH-deep shift RAM, one read and one write per advance
// Purpose: delays a pixel stream by exactly DEPTH advances. dout is the sample
//          written DEPTH advances ago; on adv the new sample overwrites it.
//          Contents are not cleared by reset, only the pointer is.
// Ports:
//   clk  in  1   rising-edge clock
//   rst  in  1   asynchronous reset, active-high
//   adv  in  1   shift enable
//   din  in  DW  sample shifted in
//   dout out DW  sample leaving the delay line
module line_buffer
  import canny_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;

  // Read-before-write at the same address gives a delay of exactly DEPTH.
  assign dout = mem[ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/gaussian_blur_3x3.sv
// rtl/gaussian_blur_3x3.sv - streaming 3x3 Gaussian smoothing stage
// Purpose: consumes one gray pixel per accepted beat in raster order and emits
//          one smoothed pixel per input pixel. Border pixels pass through
//          unfiltered. After the last pixel of a frame the block flushes
//          WIDTH+1 zero samples to drain the window.
// Config:  GAUSS_ROUND_EN defined -> round-half-up (sum+8)>>4, else truncate sum>>4.
// Ports:
//   clk       in  1   rising-edge clock
//   rst       in  1   asynchronous reset, active-high
//   in_valid  in  1   in_pixel valid
//   in_ready  out 1   accepting input (low during flush)
//   in_pixel  in  DW  gray pixel, raster order
//   out_valid out 1   out_pixel valid (one pulse per pixel)
//   out_pixel out DW  smoothed pixel, raster order
//   out_last  out 1   with out_valid on pixel (HEIGHT-1, WIDTH-1)
//   busy      out 1   frame in progress, through the out_last cycle
module gaussian_blur_3x3
  import canny_pkg::*;
#(
  parameter int WIDTH  = 512,
  parameter int HEIGHT = 512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_pixel,
  output logic          out_valid,
  output logic [DW-1:0] out_pixel,
  output logic          out_last,
  output logic          busy
);

  localparam int NPIX = WIDTH * HEIGHT;
  localparam int NMAX = NPIX + WIDTH;          // index of the final flush advance
  localparam int NW   = $clog2(NMAX + 1);
  localparam int CW   = $clog2(WIDTH);
  localparam int RW   = $clog2(HEIGHT);

  blur_state_t   state;
  logic [NW-1:0] n;        // linear index of the next advance
  logic [RW-1:0] orow;     // position of the next produced output
  logic [CW-1:0] ocol;

  logic          adv;
  logic [DW-1:0] sample;
  logic [DW-1:0] lb0_out;
  logic [DW-1:0] lb1_out;

  logic [DW-1:0] win  [3][3];   // [row][col], row 2 / col 2 newest
  logic [DW-1:0] nwin [3][3];

  logic [SUM_W-1:0] sum;
  logic [DW-1:0]    filt;
  logic             produce;
  logic             border;
  logic             last_adv;

  assign in_ready = (state == RUN);
  assign adv      = (state == RUN) ? in_valid : 1'b1;
  assign sample   = (state == RUN) ? in_pixel : '0;
  assign last_adv = (state == FLUSH) && (n == NW'(NMAX));

  // The window centre after an advance of index n is pixel n-WIDTH-1.
  assign produce  = adv && (n >= NW'(WIDTH + 1));
  assign border   = (orow == '0) || (orow == RW'(HEIGHT - 1)) ||
                    (ocol == '0) || (ocol == CW'(WIDTH - 1));

  line_buffer #(.DEPTH(WIDTH)) u_lb0 (
    .clk  (clk),
    .rst  (rst),
    .adv  (adv),
    .din  (sample),
    .dout (lb0_out)
  );

  line_buffer #(.DEPTH(WIDTH)) u_lb1 (
    .clk  (clk),
    .rst  (rst),
    .adv  (adv),
    .din  (lb0_out),
    .dout (lb1_out)
  );

  // Next window: shift left, new column = {2 lines ago, 1 line ago, now}.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      nwin[r][0] = win[r][1];
      nwin[r][1] = win[r][2];
    end
    nwin[0][2] = lb1_out;
    nwin[1][2] = lb0_out;
    nwin[2][2] = sample;
  end

  always_comb begin
    sum = SUM_W'(nwin[0][0]) * SUM_W'(K_CORNER) + SUM_W'(nwin[0][1]) * SUM_W'(K_EDGE)
        + SUM_W'(nwin[0][2]) * SUM_W'(K_CORNER) + SUM_W'(nwin[1][0]) * SUM_W'(K_EDGE)
        + SUM_W'(nwin[1][1]) * SUM_W'(K_CENTRE) + SUM_W'(nwin[1][2]) * SUM_W'(K_EDGE)
        + SUM_W'(nwin[2][0]) * SUM_W'(K_CORNER) + SUM_W'(nwin[2][1]) * SUM_W'(K_EDGE)
        + SUM_W'(nwin[2][2]) * SUM_W'(K_CORNER);
  end

`ifdef GAUSS_ROUND_EN
  // Max (4080+8)>>4 = 255, so the rounded result still fits DW bits.
  assign filt = DW'((sum + SUM_W'(8)) >> 4);
`else
  assign filt = DW'(sum >> 4);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      n         <= '0;
      orow      <= '0;
      ocol      <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      out_valid <= produce;
      out_last  <= produce && (orow == RW'(HEIGHT - 1)) && (ocol == CW'(WIDTH - 1));

      if (produce) begin
        out_pixel <= border ? nwin[1][1] : filt;
        if (ocol == CW'(WIDTH - 1)) begin
          ocol <= '0;
          orow <= (orow == RW'(HEIGHT - 1)) ? '0 : orow + 1'b1;
        end else begin
          ocol <= ocol + 1'b1;
        end
      end

      if (adv) begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            win[r][c] <= nwin[r][c];
          end
        end
        n <= last_adv ? '0 : n + 1'b1;
      end

      case (state)
        RUN:     if (in_valid && (n == NW'(NPIX - 1))) state <= FLUSH;
        FLUSH:   if (last_adv) state <= RUN;
        default: state <= RUN;
      endcase

      // A new frame accepted in the out_last cycle keeps busy high.
      if ((state == RUN) && in_valid) begin
        busy <= 1'b1;
      end else if (out_last) begin
        busy <= 1'b0;
      end
    end
  end

endmodule
